// File: rtl/counter_down_8bit_pkg.sv
// Shared definitions for the counters library: FSM state encodings and default counter width.
package counter_down_8bit_pkg;

    localparam int CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/counter_down_8bit.sv
// Loadable down-counter/timer with a one-cycle terminal-count pulse and optional auto-reload.
// Latency: load visible one edge after sampling; all outputs registered. Gated by ce, then load > en.
module counter_down_8bit
    import counter_down_8bit_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             reload_en,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rld_d   = rld_q;
        tc_d    = 1'b0;
        if (ce) begin
            if (load) begin
                cnt_d   = d;
                rld_d   = d;
                state_d = (d != '0) ? ST_RUN : ST_IDLE;
            end else if (state_q == ST_RUN && en) begin
                // Intercepting q==1 here is what keeps the count from wrapping below zero.
                if (cnt_q == WIDTH'(1)) begin
                    tc_d = 1'b1;
                    if (reload_en) begin
                        cnt_d = rld_q;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
        end
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rld_q   <= '0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rld_q   <= rld_d;
            tc_q    <= tc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign q    = cnt_q;
    assign tc   = tc_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_counter_down_8bit.sv
// Randomized and directed checks of counter_down_8bit against a behavioural timer model.
module tb_counter_down_8bit;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce, en, load, reload_en;
    logic [7:0] d;
    logic [7:0] q;
    logic       tc, busy, done;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: remaining count, period, and a phase name (0 idle, 1 running, 2 finished).
    int m_remaining, m_period, m_phase;
    bit m_tc;

    counter_down_8bit #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .en        (en),
        .load      (load),
        .d         (d),
        .reload_en (reload_en),
        .q         (q),
        .tc        (tc),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_remaining = 0;
        m_period    = 0;
        m_phase     = 0;
        m_tc        = 1'b0;
    endtask

    // One clock edge of the timer, described as "remaining ticks until expiry".
    task automatic model_edge();
        m_tc = 1'b0;
        if (!ce) return;
        if (load) begin
            m_remaining = int'(d);
            m_period    = int'(d);
            m_phase     = (d == 0) ? 0 : 1;
            return;
        end
        if (m_phase != 1 || !en) return;
        m_remaining = m_remaining - 1;
        if (m_remaining == 0) begin
            m_tc = 1'b1;
            if (reload_en) m_remaining = m_period;
            else           m_phase     = 2;
        end
    endtask

    task automatic compare_all();
        chk("q",    32'(q),    32'(m_remaining));
        chk("tc",   32'(tc),   32'(m_tc));
        chk("busy", 32'(busy), 32'(m_phase == 1));
        chk("done", 32'(done), 32'(m_phase == 2));
    endtask

    task automatic step(input logic c, input logic e, input logic l,
                        input logic [7:0] dv, input logic r);
        ce = c; en = e; load = l; d = dv; reload_en = r;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    int cycles;

    initial begin
        reset = 1'b0; ce = 1'b0; en = 1'b0; load = 1'b0; d = '0; reload_en = 1'b0;
        model_reset();
        #1;
        chk("reset_q", 32'(q), 0);
        chk("reset_flags", 32'({tc, busy, done}), 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // One-shot from 5.
        step(1, 1, 1, 8'd5, 0);
        chk("os_load_q", 32'(q), 5);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 8'd0, 0);
        chk("os_tc", 32'(tc), 1);
        chk("os_done", 32'(done), 1);
        step(1, 1, 0, 8'd0, 0);
        chk("os_tc_one_cycle", 32'(tc), 0);
        chk("os_hold_q", 32'(q), 0);

        // Auto-reload from 3: tc every third edge.
        step(1, 1, 1, 8'd3, 1);
        for (int i = 1; i <= 9; i++) begin
            step(1, 1, 0, 8'd0, 1);
            chk("rl_tc_period", 32'(tc), 32'(i % 3 == 0));
            chk("rl_busy", 32'(busy), 1);
        end

        // Load 4 with three gap cycles: tc after 7 edges instead of 4.
        step(1, 1, 1, 8'd4, 0);
        begin
            logic ce_pat [7] = '{1, 1, 1, 0, 1, 1, 1};
            logic en_pat [7] = '{1, 0, 0, 1, 1, 1, 1};
            cycles = 0;
            for (int i = 0; i < 7; i++) begin
                step(ce_pat[i], en_pat[i], 0, 8'd0, 0);
                if (tc) cycles = i + 1;
            end
            chk("gap_tc_edge", 32'(cycles), 7);
        end

        // Load at q==1 overrides the terminal step.
        step(1, 1, 1, 8'd2, 0);
        step(1, 1, 0, 8'd0, 0);
        chk("ld1_q_one", 32'(q), 1);
        step(1, 1, 1, 8'd9, 0);
        chk("ld1_q", 32'(q), 9);
        chk("ld1_tc", 32'(tc), 0);
        chk("ld1_busy", 32'(busy), 1);

        // Load zero goes idle.
        step(1, 1, 1, 8'd0, 1);
        chk("ld0_busy", 32'(busy), 0);
        chk("ld0_tc", 32'(tc), 0);

        // Asynchronous reset mid-count at q==2.
        step(1, 1, 1, 8'd4, 0);
        step(1, 1, 0, 8'd0, 0);
        step(1, 1, 0, 8'd0, 0);
        chk("ar_pre_q", 32'(q), 2);
        #1 reset = 1'b0;
        #1;
        chk("ar_q", 32'(q), 0);
        chk("ar_flags", 32'({tc, busy, done}), 0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 8'd0, 1);
            chk("ar_no_tc", 32'(tc), 0);
        end

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic       rc, re, rl, rr;
            logic [7:0] rd;
            rc = ($urandom_range(0, 9) != 0);
            re = ($urandom_range(0, 5) != 0);
            rl = ($urandom_range(0, 14) == 0);
            rr = $urandom_range(0, 1) != 0;
            case ($urandom_range(0, 3))
                0:       rd = 8'd0;
                1:       rd = 8'd1;
                2:       rd = 8'($urandom_range(2, 12));
                default: rd = 8'($urandom);
            endcase
            step(rc, re, rl, rd, rr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
